// File: rtl/mem_side_pkg.sv
// Shared types and line geometry for the memory-side sequencer.
package mem_side_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST      = 2'd1,
        LD      = 2'd2,
        LD_LAST = 2'd3
    } state_t;

    localparam int LINE_WORDS     = 4;
    localparam int OFFSET_W       = 2;
    localparam int LINE_BYTE_BITS = 4;

endpackage

// File: rtl/req_latch.sv
// One-deep pending request register: captures on trigger when not busy, otherwise drops and flags overrun.
// Latency: pending visible one cycle after the trigger edge; no backpressure, overrun is sticky until reset.
module req_latch #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         trig,
    input  logic         busy,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic         pend,
    output logic [W-1:0] dat,
    output logic         overrun,
    output logic         accept
);

    assign accept = trig & ~busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            dat     <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                pend <= 1'b1;
                dat  <= din;
            end else if (clr) begin
                pend <= 1'b0;
            end
            if (trig && busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_side_sequencer.sv
// Sequences write-buffer drains and 4-word line fills onto one memory port; stores win over loads.
// Latency: request on the port the cycle after the trigger; each mem_ack wait state stretches the beat by one cycle.
module mem_side_sequencer
    import mem_side_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                sysclk,
    input  logic                nRESET,
    input  logic                Store_Trigger,
    input  logic [DATA_W-1:0]   write_buffer_data,
    input  logic [ADDR_W-1:0]   write_buffer_addr,
    input  logic                write_buffer_is_byte,
    input  logic                Load_Trigger,
    input  logic [ADDR_W-1:0]   load_addr,
    output logic                st_busy,
    output logic                ld_busy,
    output logic                load_from_mem_req,
    output logic [DATA_W-1:0]   load_from_mem_data,
    output logic [OFFSET_W-1:0] load_from_mem_offset,
    output logic                store_overrun,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_byte,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam int ST_W  = ADDR_W + DATA_W + 1;
    localparam int LDA_W = ADDR_W - LINE_BYTE_BITS;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [OFFSET_W-1:0] beat;

    logic             st_pend, st_acc, st_ovr, st_clr;
    logic [ST_W-1:0]  st_dat;
    logic             ld_pend, ld_acc, ld_ovr, ld_clr;
    logic [LDA_W-1:0] ld_line;
    logic             ack_ld;
    logic             unused_lo_bits;

    // Fills always start at word 0, so the miss word offset is irrelevant.
    assign unused_lo_bits = ^load_addr[LINE_BYTE_BITS-1:0];

    assign st_busy = st_pend | (state == ST);
    assign ld_busy = ld_pend | (state == LD) | (state == LD_LAST);
    assign st_clr  = (state == ST) & mem_ack;
    assign ld_clr  = (state == LD_LAST);
    assign ack_ld  = (state == LD) & mem_ack;

    assign store_overrun = st_ovr | ld_ovr;

    req_latch #(.W(ST_W)) u_st_latch (
        .clk     (sysclk),
        .rst_n   (nRESET),
        .trig    (Store_Trigger),
        .busy    (st_busy),
        .clr     (st_clr),
        .din     ({write_buffer_is_byte, write_buffer_addr, write_buffer_data}),
        .pend    (st_pend),
        .dat     (st_dat),
        .overrun (st_ovr),
        .accept  (st_acc)
    );

    req_latch #(.W(LDA_W)) u_ld_latch (
        .clk     (sysclk),
        .rst_n   (nRESET),
        .trig    (Load_Trigger),
        .busy    (ld_busy),
        .clr     (ld_clr),
        .din     (load_addr[ADDR_W-1:LINE_BYTE_BITS]),
        .pend    (ld_pend),
        .dat     (ld_line),
        .overrun (ld_ovr),
        .accept  (ld_acc)
    );

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_byte  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                // Accepted triggers are looked at directly so the port starts the next cycle.
                if (st_pend || st_acc) begin
                    state_nxt = ST;
                end else if (ld_pend || ld_acc) begin
                    state_nxt = LD;
                end
            end
            ST: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_byte  = st_dat[ST_W-1];
                mem_addr  = st_dat[DATA_W +: ADDR_W];
                mem_wdata = st_dat[DATA_W-1:0];
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            LD: begin
                mem_req  = 1'b1;
                mem_addr = {ld_line, beat, 2'b00};
                if (mem_ack && (beat == LAST_BEAT)) begin
                    state_nxt = LD_LAST;
                end
            end
            LD_LAST: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!nRESET) begin
            state                <= IDLE;
            beat                 <= '0;
            load_from_mem_req    <= 1'b0;
            load_from_mem_data   <= '0;
            load_from_mem_offset <= '0;
        end else begin
            state             <= state_nxt;
            load_from_mem_req <= ack_ld;
            if (ack_ld) begin
                load_from_mem_data   <= mem_rdata;
                load_from_mem_offset <= beat;
                if (beat != LAST_BEAT) begin
                    beat <= beat + 1'b1;
                end
            end
            if ((state == IDLE) && (state_nxt == LD)) begin
                beat <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_side_sequencer.sv
// Bench: directed timing cases plus randomized mixed traffic against a transaction-queue model.
module tb_mem_side_sequencer;

    logic        sysclk = 1'b0;
    logic        nRESET = 1'b0;
    logic        Store_Trigger = 1'b0;
    logic [31:0] write_buffer_data = '0;
    logic [31:0] write_buffer_addr = '0;
    logic        write_buffer_is_byte = 1'b0;
    logic        Load_Trigger = 1'b0;
    logic [31:0] load_addr = '0;
    logic        st_busy, ld_busy, load_from_mem_req, store_overrun;
    logic [31:0] load_from_mem_data;
    logic [1:0]  load_from_mem_offset;
    logic        mem_req, mem_we, mem_byte;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    always #5 sysclk = ~sysclk;

    mem_side_sequencer #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
        .sysclk               (sysclk),
        .nRESET               (nRESET),
        .Store_Trigger        (Store_Trigger),
        .write_buffer_data    (write_buffer_data),
        .write_buffer_addr    (write_buffer_addr),
        .write_buffer_is_byte (write_buffer_is_byte),
        .Load_Trigger         (Load_Trigger),
        .load_addr            (load_addr),
        .st_busy              (st_busy),
        .ld_busy              (ld_busy),
        .load_from_mem_req    (load_from_mem_req),
        .load_from_mem_data   (load_from_mem_data),
        .load_from_mem_offset (load_from_mem_offset),
        .store_overrun        (store_overrun),
        .mem_req              (mem_req),
        .mem_we               (mem_we),
        .mem_byte             (mem_byte),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .mem_rdata            (mem_rdata),
        .mem_ack              (mem_ack)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: ordered queue of memory transactions the bench expects to see.
    typedef struct packed {
        logic        we;
        logic        byt;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    bit   data_mode = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (data_mode)
            return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
        return 32'h12345678 + {30'd0, a[3:2]};
    endfunction

    // Memory responder and port monitor.
    int   cur_wait = 0, waited = 0, wait_lo = 0, wait_hi = 0;
    bit   spur_en = 1'b0;
    logic ack_given = 1'b0;
    logic prev_req = 1'b0;
    logic [31:0] prev_addr = '0;
    txn_t pend_txn, exp_e;
    logic exp_strb;

    initial begin
        forever begin
            @(negedge sysclk);
            exp_strb = 1'b0;
            if (ack_given && nRESET) begin
                chk("txn_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    chk("txn", pend_txn, exp_e);
                    exp_strb = !exp_e.we;
                end
            end
            chk("strobe", load_from_mem_req, exp_strb);
            if (exp_strb && load_from_mem_req) begin
                chk("fill_data", load_from_mem_data, mem_word(exp_e.addr));
                chk("fill_offset", load_from_mem_offset, exp_e.addr[3:2]);
            end
            if (prev_req && !ack_given && nRESET) begin
                chk("req_hold", mem_req, 1'b1);
                chk("addr_hold", mem_addr, prev_addr);
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
            if (mem_req) begin
                if (waited >= cur_wait) begin
                    ack_given = 1'b1;
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    pend_txn  = {mem_we, mem_byte, mem_addr, (mem_we ? mem_wdata : 32'h0)};
                    waited    = 0;
                    cur_wait  = $urandom_range(wait_hi, wait_lo);
                end else begin
                    ack_given = 1'b0;
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    waited++;
                end
            end else begin
                ack_given = 1'b0;
                mem_ack   = spur_en && ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    task automatic tick();
        @(negedge sysclk);
        #1;
    endtask

    task automatic set_wait(input int lo, input int hi);
        wait_lo  = lo;
        wait_hi  = hi;
        waited   = 0;
        cur_wait = $urandom_range(hi, lo);
    endtask

    task automatic issue(input bit s, input bit l, input logic [31:0] sa, input logic [31:0] sd,
                         input bit sb, input logic [31:0] la, input bit acc);
        Store_Trigger        = s;
        Load_Trigger         = l;
        write_buffer_addr    = sa;
        write_buffer_data    = sd;
        write_buffer_is_byte = sb;
        load_addr            = la;
        if (acc && s) exp_q.push_back({1'b1, sb, sa, sd});
        if (acc && l)
            for (int k = 0; k < 4; k++)
                exp_q.push_back({1'b0, 1'b0, {la[31:4], 4'h0} + 32'(4 * k), 32'h0});
        tick();
        Store_Trigger        = 1'b0;
        Load_Trigger         = 1'b0;
        write_buffer_addr    = $urandom;
        write_buffer_data    = $urandom;
        write_buffer_is_byte = 1'b0;
        load_addr            = $urandom;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || st_busy || ld_busy) && n < limit) begin
            tick();
            n++;
        end
        chk("drain", {exp_q.size() == 0, !st_busy, !ld_busy}, 3'b111);
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        exp_q.delete();
        waited = 0;
        tick();
        chk("reset_outputs", {st_busy, ld_busy, load_from_mem_req, load_from_mem_data,
                              load_from_mem_offset, store_overrun, mem_req, mem_we, mem_byte,
                              mem_addr, mem_wdata}, '0);
        repeat (2) tick();
        nRESET = 1'b1;
        tick();
    endtask

    // Bit i of each mask is the expectation for cycle N+1+i after the trigger edge N.
    task automatic check_seq(input string tag, input int n, input logic [15:0] e_req,
                             input logic [15:0] e_we, input logic [15:0] e_stb, input logic [15:0] e_ldb);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_mem_req"}, mem_req, e_req[i]);
            chk({tag, "_mem_we"}, mem_we, e_we[i]);
            chk({tag, "_st_busy"}, st_busy, e_stb[i]);
            chk({tag, "_ld_busy"}, ld_busy, e_ldb[i]);
            tick();
        end
    endtask

    initial begin
        tick();
        do_reset();

        // Zero-wait fill of line 0x400 from a miss at 0x401.
        data_mode = 1'b0;
        set_wait(0, 0);
        issue(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h401, 1'b1);
        chk("t1_first_addr", mem_addr, 32'h400);
        check_seq("t1", 6, 16'b001111, 16'b0, 16'b0, 16'b011111);
        wait_idle(50);

        // Word store with three wait states.
        data_mode = 1'b1;
        set_wait(3, 3);
        issue(1'b1, 1'b0, 32'h2, 32'hABCD9876, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr", mem_addr, 32'h2);
            chk("t2_wdata", mem_wdata, 32'hABCD9876);
            check_seq("t2", 1, 16'b1, 16'b1, 16'b1, 16'b0);
        end
        check_seq("t2_end", 1, 16'b0, 16'b0, 16'b0, 16'b0);
        wait_idle(50);

        // Simultaneous byte store and fill to 0x10: store first, one idle cycle, then the fill.
        set_wait(0, 0);
        issue(1'b1, 1'b1, 32'h10, 32'h000000A5, 1'b1, 32'h10, 1'b1);
        check_seq("t3", 8, 16'b00111101, 16'b00000001, 16'b00000001, 16'b01111111);
        wait_idle(50);

        // Second store while busy is dropped and flags overrun.
        chk("t4_overrun_before", store_overrun, 1'b0);
        set_wait(2, 2);
        issue(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 32'h200, 32'h0BADBEEF, 1'b1, 32'h0, 1'b0);
        chk("t4_overrun_set", store_overrun, 1'b1);
        wait_idle(50);
        repeat (3) tick();
        chk("t4_overrun_sticky", store_overrun, 1'b1);

        do_reset();
        chk("t5_overrun_cleared", store_overrun, 1'b0);

        // Second fill while a fill is busy is dropped the same way.
        set_wait(1, 1);
        issue(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h3004, 1'b1);
        issue(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h5000, 1'b0);
        chk("t6_ld_overrun", store_overrun, 1'b1);
        wait_idle(50);

        // Reset during fill beat 2, then a fresh fill must start at word 0.
        do_reset();
        data_mode = 1'b0;
        set_wait(0, 0);
        issue(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h777C, 1'b1);
        tick();
        tick();
        chk("t7_beat2_addr", mem_addr, 32'h7778);
        do_reset();
        set_wait(0, 0);
        issue(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h888C, 1'b1);
        chk("t7_restart_addr", mem_addr, 32'h8880);
        wait_idle(50);

        // Randomized mixed traffic with stalls and stray acks while idle.
        data_mode = 1'b1;
        spur_en   = 1'b1;
        set_wait(0, 5);
        for (int it = 0; it < 100; it++) begin
            int kind;
            kind = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) tick();
            issue(kind != 1, kind != 0, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 1'b1);
            wait_idle(300);
        end
        spur_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
